ta_fifo_packer: RTL and testbench



---
 rtl/ta_pkg.sv | 11 +
 rtl/ta_pkt_fifo.sv | 57 +++++
 rtl/ta_fifo_packer.sv | 91 +++++++++
 tb/tb_ta_fifo_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ta_pkg.sv
// Shared types and constants for the TA parameter FIFO packer.
package ta_pkg;
    localparam int TA_PKT_W = 256;
    localparam int TA_WORDS = 8;

    localparam logic [7:0] TA_MASK_Q  = 8'hFF;
    localparam logic [7:0] TA_MASK_LO = 8'h0F;
    localparam logic [7:0] TA_MASK_HI = 8'hF0;

    typedef logic [TA_PKT_W-1:0] ta_pkt_t;
endpackage

// File: rtl/ta_pkt_fifo.sv
// Packet FIFO, DEPTH x 256 bits, with a registered head output and a level count.
module ta_pkt_fifo
    import ta_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [TA_PKT_W-1:0]       push_data,
    input  logic                      pkt_ready,
    output logic                      pkt_valid,
    output logic [TA_PKT_W-1:0]       pkt_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic [$clog2(DEPTH):0]    level_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    ta_pkt_t mem [DEPTH];

    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
    logic          pop, push_ok;

    assign pop        = pkt_valid & pkt_ready;
    assign push_ok    = push & (level != FULL);
    assign rd_ptr_n   = rd_ptr + AW'(pop);
    assign level_next = level + LW'(push_ok) - LW'(pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push_ok);
            rd_ptr    <= rd_ptr_n;
            level     <= level_next;
            pkt_valid <= (level_next != '0);
            // A push into an otherwise empty FIFO becomes the head directly.
            if (push_ok && level_next == LW'(1)) begin
                pkt_data <= push_data;
            end else if (level_next != '0) begin
                pkt_data <= mem[rd_ptr_n];
            end
        end
    end
endmodule

// File: rtl/ta_fifo_packer.sv
// Packs 32/64-bit SH4 stores into 32-byte TA packets and queues them for the TA.
module ta_fifo_packer
    import ta_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [63:0]               wr_data,
    input  logic [7:0]                wr_mask,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [TA_PKT_W-1:0]       pkt_data,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [2:0]                word_cnt,
    output logic                      err_mask,
    input  logic                      err_clr
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [TA_WORDS-1:0][31:0] asm_q, asm_n;
    logic [2:0]                wc_n;
    logic                      accept, push, err_set;
    ta_pkt_t                   push_data;
    logic [LW-1:0]             level_next;

    assign accept = wr_valid & wr_ready;

    always_comb begin
        asm_n     = asm_q;
        wc_n      = word_cnt;
        push      = 1'b0;
        push_data = '0;
        err_set   = 1'b0;
        if (accept) begin
            case (wr_mask)
                TA_MASK_Q: begin
                    asm_n[word_cnt] = wr_data[31:0];
                    if (word_cnt == 3'd7) begin
                        // Straddle: low word closes this packet, high word opens the next.
                        push      = 1'b1;
                        push_data = asm_n;
                        asm_n[0]  = wr_data[63:32];
                        wc_n      = 3'd1;
                    end else begin
                        asm_n[word_cnt + 3'd1] = wr_data[63:32];
                        wc_n      = word_cnt + 3'd2;
                        push      = (word_cnt == 3'd6);
                        push_data = asm_n;
                    end
                end
                TA_MASK_LO, TA_MASK_HI: begin
                    asm_n[word_cnt] = (wr_mask == TA_MASK_LO) ? wr_data[31:0] : wr_data[63:32];
                    wc_n      = word_cnt + 3'd1;
                    push      = (word_cnt == 3'd7);
                    push_data = asm_n;
                end
                default: err_set = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q    <= '0;
            word_cnt <= '0;
            err_mask <= 1'b0;
            wr_ready <= 1'b0;
        end else begin
            asm_q    <= asm_n;
            word_cnt <= wc_n;
            err_mask <= err_set | (err_mask & ~err_clr);
            wr_ready <= (level_next < FULL);
        end
    end

    ta_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pkt_ready  (pkt_ready),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .level      (fifo_level),
        .level_next (level_next)
    );
endmodule

// File: tb/tb_ta_fifo_packer.sv
// Self-checking bench for ta_fifo_packer against a queue-based packet model.
module tb_ta_fifo_packer;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [63:0]  wr_data;
    logic [7:0]   wr_mask;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [255:0] pkt_data;
    logic [2:0]   fifo_level;
    logic [2:0]   word_cnt;
    logic         err_mask;
    logic         err_clr;

    int checks = 0;
    int errors = 0;
    int word_ctr = 0;

    // Reference model: pending words, queued packets, sticky error, registered ready.
    logic [31:0]  part[$];
    logic [255:0] q[$];
    bit           m_err;
    bit           m_ready;

    ta_fifo_packer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .fifo_level (fifo_level),
        .word_cnt   (word_cnt),
        .err_mask   (err_mask),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        part.delete();
        q.delete();
        m_err   = 0;
        m_ready = 0;
    endtask

    task automatic add_word(input logic [31:0] w);
        logic [255:0] p;
        part.push_back(w);
        if (part.size() == 8) begin
            for (int i = 0; i < 8; i++) p[32*i +: 32] = part[i];
            q.push_back(p);
            part.delete();
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wr_ready"},   wr_ready,   m_ready);
        chk({tag, ".pkt_valid"},  pkt_valid,  q.size() != 0);
        chk({tag, ".fifo_level"}, fifo_level, q.size());
        chk({tag, ".word_cnt"},   word_cnt,   part.size());
        chk({tag, ".err_mask"},   err_mask,   m_err);
        if (q.size() != 0) chk({tag, ".pkt_data"}, pkt_data, q[0]);
    endtask

    task automatic cycle(input string tag);
        bit acc;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc = wr_valid && m_ready;
            if (q.size() != 0 && pkt_ready) void'(q.pop_front());
            if (acc) begin
                case (wr_mask)
                    8'hFF: begin add_word(wr_data[31:0]); add_word(wr_data[63:32]); end
                    8'h0F: add_word(wr_data[31:0]);
                    8'hF0: add_word(wr_data[63:32]);
                    default: ;
                endcase
            end
            if (acc && !(wr_mask inside {8'hFF, 8'h0F, 8'hF0})) m_err = 1;
            else if (err_clr) m_err = 0;
            m_ready = q.size() < DEPTH;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic store(input logic [63:0] d, input logic [7:0] m, input logic pr);
        int  n = 0;
        bit  done = 0;
        wr_valid = 1; wr_data = d; wr_mask = m; pkt_ready = pr;
        while (!done) begin
            done = m_ready;
            cycle("store");
            n++;
            if (!done && n > 64) begin
                chk("store_timeout", 1'b0, 1'b1);
                done = 1;
            end
        end
        wr_valid = 0; pkt_ready = 0;
    endtask

    task automatic fill(input int n, input logic pr);
        for (int i = 0; i < n; i++) begin
            store({32'h0, 32'(word_ctr)}, 8'h0F, pr);
            word_ctr++;
        end
    endtask

    task automatic idle(input int n, input logic pr);
        wr_valid = 0; pkt_ready = pr;
        for (int i = 0; i < n; i++) cycle("idle");
        pkt_ready = 0;
    endtask

    initial begin
        logic [255:0] exp;
        rst = 1; wr_valid = 0; wr_data = '0; wr_mask = '0; pkt_ready = 0; err_clr = 0;
        model_reset();
        #3;
        check_all("reset");
        chk("reset.pkt_data", pkt_data, 256'h0);
        cycle("rst_hold");
        rst = 0;
        cycle("rst_release");
        chk("ready_after_reset", wr_ready, 1'b1);

        // Eight 32-bit stores build packet {7..0}
        for (int n = 0; n < 8; n++) store(64'(n), 8'h0F, 1'b0);
        for (int i = 0; i < 8; i++) exp[32*i +: 32] = 32'(i);
        chk("t1.pkt_data", pkt_data, exp);
        chk("t1.pkt_valid", pkt_valid, 1'b1);
        chk("t1.level", fifo_level, 3'd1);

        // Four 64-bit stores, then a straddling store at word_cnt 7
        for (int k = 0; k < 4; k++) store({32'(2*k+1), 32'(2*k)}, 8'hFF, 1'b0);
        chk("t2.level", fifo_level, 3'd2);
        for (int k = 0; k < 3; k++) store({32'(k+101), 32'(k+100)}, 8'hFF, 1'b0);
        store(64'h0000_0000_0000_0077, 8'h0F, 1'b0);
        chk("t2.wc7", word_cnt, 3'd7);
        store({32'hBB, 32'hAA}, 8'hFF, 1'b0);
        chk("t2.wc_straddle", word_cnt, 3'd1);
        chk("t2.level3", fifo_level, 3'd3);

        // Fill to DEPTH under backpressure, then one pop
        fill(7, 1'b0);
        chk("t3.level_full", fifo_level, 3'd4);
        chk("t3.ready_low", wr_ready, 1'b0);
        idle(3, 1'b0);
        chk("t3.still_low", wr_ready, 1'b0);
        idle(1, 1'b1);
        chk("t3.ready_high", wr_ready, 1'b1);
        chk("t3.level_after_pop", fifo_level, 3'd3);
        idle(4, 1'b1);
        chk("t3.drained", fifo_level, 3'd0);

        // Illegal mask at word_cnt 3
        fill(3, 1'b0);
        store(64'hDEAD_BEEF_CAFE_F00D, 8'h33, 1'b0);
        chk("t4.err", err_mask, 1'b1);
        chk("t4.wc", word_cnt, 3'd3);
        err_clr = 1; idle(1, 1'b0); err_clr = 0;
        chk("t4.err_clr", err_mask, 1'b0);
        err_clr = 1; store(64'h1, 8'h01, 1'b0); err_clr = 0;
        chk("t4.err_clr_vs_set", err_mask, 1'b1);
        err_clr = 1; idle(1, 1'b0); err_clr = 0;

        // Simultaneous push and pop at level 2
        fill(5, 1'b0);
        fill(8, 1'b0);
        chk("t5.level2", fifo_level, 3'd2);
        fill(7, 1'b0);
        fill(1, 1'b1);
        chk("t5.level_same", fifo_level, 3'd2);
        idle(3, 1'b1);

        // Reset with word_cnt 5, level 3
        fill(29, 1'b0);
        chk("t6.level3", fifo_level, 3'd3);
        chk("t6.wc5", word_cnt, 3'd5);
        #2 rst = 1;
        #1 model_reset();
        check_all("t6.async_reset");
        chk("t6.pkt_data_zero", pkt_data, 256'h0);
        @(negedge clk);
        cycle("t6.hold");
        rst = 0;
        cycle("t6.release");
        for (int i = 0; i < 8; i++) begin
            store({32'h0, 32'hA000 + 32'(i)}, 8'h0F, 1'b0);
            exp[32*i +: 32] = 32'hA000 + 32'(i);
        end
        chk("t6.fresh_pkt", pkt_data, exp);
        chk("t6.fresh_level", fifo_level, 3'd1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 9);
            wr_valid  = $urandom_range(0, 3) != 0;
            wr_data   = {$urandom, $urandom};
            wr_mask   = (r < 3) ? 8'hFF : (r < 6) ? 8'h0F : (r < 9) ? 8'hF0 : 8'($urandom);
            pkt_ready = $urandom_range(0, 2) == 0;
            err_clr   = $urandom_range(0, 15) == 0;
            cycle("rand");
        end
        wr_valid = 0; err_clr = 0;
        idle(8, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
